// File: rtl/rr_arb.sv
// rr_arb: W-way round-robin arbiter. Registered one-hot grant 1 cycle after request, held until i_ack.
// On ack the next grant loads back-to-back. `RR_ARB_LOCK_EN adds i_lock to retain a grant.
module rr_arb #(
  parameter  int W     = 4,
  localparam int ENC_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     i_req,
  input  logic             i_ack,
`ifdef RR_ARB_LOCK_EN
  input  logic             i_lock,
`endif
  output logic [W-1:0]     o_gnt,
  output logic             o_gnt_vld,
  output logic [ENC_W-1:0] o_gnt_enc
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_BUSY = 1'b1;
  localparam logic [ENC_W-1:0] LAST    = ENC_W'(W - 1);

  logic [0:0]       r_state;
  logic [ENC_W-1:0] r_ptr;
  logic [W-1:0]     r_gnt;
  logic [ENC_W-1:0] r_gnt_enc;
  logic             r_gnt_vld;

  logic             w_accept;
  logic             w_lock_hold;
  logic             w_advance;
  logic [ENC_W-1:0] w_ptr_inc;
  logic [ENC_W-1:0] w_pick_ptr;
  logic [W-1:0]     w_cand;
  logic [W-1:0]     w_hi_mask;
  logic [W-1:0]     w_cand_hi;
  logic [W-1:0]     w_pick_src;
  logic [ENC_W-1:0] w_win_enc;
  logic             w_win_vld;
  logic [W-1:0]     w_win;

  assign w_accept = (r_state == ST_BUSY) && i_ack;

`ifdef RR_ARB_LOCK_EN
  // Lock only sticks while the owner is still requesting.
  assign w_lock_hold = w_accept && i_lock && (|(i_req & r_gnt));
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_advance = w_accept && !w_lock_hold;

  // Explicit wrap so non-power-of-two W stays inside 0..W-1.
  assign w_ptr_inc = (r_gnt_enc == LAST) ? '0 : (r_gnt_enc + ENC_W'(1));

  // In BUSY the search starts past the requester being served and excludes it.
  assign w_cand     = (r_state == ST_IDLE) ? i_req : (i_req & ~r_gnt);
  assign w_pick_ptr = (r_state == ST_IDLE) ? r_ptr : w_ptr_inc;

  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < W; i++) begin
      w_hi_mask[i] = (ENC_W'(i) >= w_pick_ptr);
    end
  end

  assign w_cand_hi  = w_cand & w_hi_mask;
  assign w_pick_src = (|w_cand_hi) ? w_cand_hi : w_cand;

  always_comb begin
    w_win_enc = '0;
    w_win_vld = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (w_pick_src[i]) begin
        w_win_enc = ENC_W'(i);
        w_win_vld = 1'b1;
      end
    end
  end

  assign w_win = w_win_vld ? (W'(1) << w_win_enc) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_enc <= '0;
      r_gnt_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_gnt     <= w_win;
            r_gnt_enc <= w_win_enc;
            r_gnt_vld <= 1'b1;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_advance) begin
            r_ptr <= w_ptr_inc;
            if (w_win_vld) begin
              r_gnt     <= w_win;
              r_gnt_enc <= w_win_enc;
            end else begin
              r_gnt     <= '0;
              r_gnt_enc <= '0;
              r_gnt_vld <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_vld = r_gnt_vld;
  assign o_gnt_enc = r_gnt_enc;

endmodule

// File: tb/tb_rr_arb.sv
// Bench for rr_arb: directed scenarios then random traffic against a circular-search reference model.
module tb_rr_arb;
  localparam int W     = 4;
  localparam int ENC_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     req;
  logic             ack;
  logic             lock;
  logic [W-1:0]     o_gnt;
  logic             o_gnt_vld;
  logic [ENC_W-1:0] o_gnt_enc;

  int n_checks = 0;
  int n_pass   = 0;
  int m_gnt    = -1;   // granted requester index, -1 when none
  int m_ptr    = 0;

  always #5 clk = ~clk;

  rr_arb #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req),
    .i_ack     (ack),
`ifdef RR_ARB_LOCK_EN
    .i_lock    (lock),
`endif
    .o_gnt     (o_gnt),
    .o_gnt_vld (o_gnt_vld),
    .o_gnt_enc (o_gnt_enc)
  );

  function automatic int rr_pick(input logic [W-1:0] c, input int start);
    for (int k = 0; k < W; k++) begin
      int idx;
      idx = (start + k) % W;
      if (c[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [W-1:0] cand;
    int served;
    if (!rst_n) begin
      m_gnt = -1;
      m_ptr = 0;
    end else if (m_gnt < 0) begin
      m_gnt = rr_pick(req, m_ptr);
    end else if (ack) begin
`ifdef RR_ARB_LOCK_EN
      if (lock && req[m_gnt]) return;
`endif
      served       = m_gnt;
      m_ptr        = (served + 1) % W;
      cand         = req;
      cand[served] = 1'b0;
      m_gnt        = rr_pick(cand, m_ptr);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [W-1:0] exp_gnt;
    exp_gnt = '0;
    if (m_gnt >= 0) exp_gnt[m_gnt] = 1'b1;
    chk("model_gnt", 32'(o_gnt), 32'(exp_gnt));
    chk("model_vld", 32'(o_gnt_vld), 32'(m_gnt >= 0));
    chk("model_enc", 32'(o_gnt_enc), (m_gnt >= 0) ? 32'(m_gnt) : 32'd0);
  endtask

  task automatic step(input logic [W-1:0] r, input logic a, input logic l, input logic rn);
    req   = r;
    ack   = a;
    lock  = l;
    rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    logic [W-1:0] v;
    req   = '1;
    ack   = 1'b0;
    lock  = 1'b0;
    rst_n = 1'b0;

    // Reset with everyone requesting.
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("rst_gnt", 32'(o_gnt), 32'd0);
    chk("rst_vld", 32'(o_gnt_vld), 32'd0);
    chk("rst_enc", 32'(o_gnt_enc), 32'd0);

    step(4'b1111, 1'b0, 1'b0, 1'b1);
    chk("first_gnt", 32'(o_gnt), 32'b0001);

    // Rotation with continuous ack.
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, 1'b1, 1'b0, 1'b1);
      chk("rot_enc", 32'(o_gnt_enc), 32'((k + 1) % W));
      chk("rot_vld", 32'(o_gnt_vld), 32'd1);
    end

    // Wrap with gaps: just served 2, only 0 and 1 request.
    step(4'b0011, 1'b1, 1'b0, 1'b1);
    chk("wrap_enc0", 32'(o_gnt_enc), 32'd0);
    step(4'b0011, 1'b1, 1'b0, 1'b1);
    chk("wrap_enc1", 32'(o_gnt_enc), 32'd1);
    step(4'b0011, 1'b1, 1'b0, 1'b1);
    chk("wrap_enc2", 32'(o_gnt_enc), 32'd0);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("drain_vld", 32'(o_gnt_vld), 32'd0);

    // Hold without ack while requests churn.
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    chk("hold_first", 32'(o_gnt), 32'b0100);
    for (int k = 0; k < 5; k++) begin
      v = W'($urandom);
      step(v, 1'b0, 1'b0, 1'b1);
      chk("hold_gnt", 32'(o_gnt), 32'b0100);
      chk("hold_enc", 32'(o_gnt_enc), 32'd2);
    end
    step(4'b1011, 1'b1, 1'b0, 1'b1);
    chk("hold_next", 32'(o_gnt_enc), 32'd3);
    step(4'b0000, 1'b1, 1'b0, 1'b1);

    // Single requester: one grant every two cycles.
    for (int k = 0; k < 6; k++) begin
      step(4'b1000, 1'b1, 1'b0, 1'b1);
      chk("single_vld", 32'(o_gnt_vld), 32'((k % 2) == 0));
      if (o_gnt_vld) chk("single_enc", 32'(o_gnt_enc), 32'd3);
    end

`ifdef RR_ARB_LOCK_EN
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    chk("lock_start", 32'(o_gnt_enc), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(4'b0011, 1'b1, 1'b1, 1'b1);
      chk("lock_hold", 32'(o_gnt), 32'b0010);
    end
    step(4'b0011, 1'b1, 1'b0, 1'b1);
    chk("lock_release", 32'(o_gnt_enc), 32'd0);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
`endif

    // Random traffic with occasional mid-grant resets.
    for (int k = 0; k < 800; k++) begin
      step(W'($urandom), ($urandom_range(0, 2) != 0), 1'($urandom),
           ($urandom_range(0, 39) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arb.md
Name: rr_arb

Overview:
- Sequential round-robin arbiter; parametrised successor to the combinational fixed-priority selector.
- Arbitrates W request lines and registers a one-hot grant that is held until the downstream consumer acknowledges it.
- Rotates priority after every accepted grant so that no requester starves.
- Sits in front of shared resources: shared ports, response buses and fill queues.

Parameters:
- W, 4: number of requesters; legal range W >= 2.
- ENC_W, $clog2(W) (localparam, not overridable): width of the encoded grant index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_req  input  W  per-requester request. A requester holds its bit high until it has been granted and acknowledged.
- i_ack  input  1  downstream accepts the current grant. Meaningful only while o_gnt_vld=1; ignored otherwise.
- o_gnt  output  W  registered one-hot grant; all zeros when o_gnt_vld=0.
- o_gnt_vld  output  1  a grant is outstanding.
- o_gnt_enc  output  ENC_W  binary index of the o_gnt bit; 0 when o_gnt_vld=0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - o_gnt=0, o_gnt_vld=0, o_gnt_enc=0.
  - Priority pointer ptr=0; state=IDLE.
  - Reset mid-grant drops the grant immediately, with no ack needed.
- State register with two states: IDLE and BUSY.
- Round-robin pick, combinational and used internally only:
  - Candidate vector c is defined per state below.
  - Winner = lowest-index set bit of c at index >= ptr.
  - If there is no such bit, winner = lowest-index set bit of c overall.
  - Wrap-around is therefore implicit; c=0 gives no winner.
- IDLE:
  - c = i_req.
  - If a winner exists: register o_gnt=onehot(winner), o_gnt_enc=winner, o_gnt_vld=1, and go to BUSY.
  - Latency from request to grant is 1 cycle.
  - Otherwise remain in IDLE with outputs 0.
- BUSY without ack (i_ack=0): all outputs hold unchanged. Changes on i_req are ignored, including a drop of the granted bit.
- BUSY with ack (i_ack=1):
  - ptr <= (o_gnt_enc + 1) mod W; the wrap W-1 -> 0 is explicit.
  - c = i_req & ~o_gnt, so the requester just served is excluded this cycle.
  - The pick uses the updated pointer value, (o_gnt_enc+1) mod W.
  - If a winner exists: load the new grant on the next edge and stay in BUSY. This gives back-to-back grants with no idle bubble.
  - Otherwise: clear all outputs and go to IDLE.
- Invariants:
  - o_gnt is always one-hot or zero.
  - o_gnt_vld == |o_gnt.
  - o_gnt_enc is consistent with o_gnt.
  - ptr changes only on an accepted grant (o_gnt_vld & i_ack) or on reset.
- Fairness: with all W requesters continuously requesting, each is granted exactly once in every W consecutive accepted grants.
- Single requester re-requesting continuously:
  - It is masked in the ack cycle, so the arbiter returns to IDLE.
  - It is re-granted one cycle later.
  - Throughput is one grant per 2 cycles for that requester.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input port i_lock (1 bit), sampled in the ack cycle.
  - If o_gnt_vld & i_ack & i_lock, and the currently granted requester still has i_req set: the grant is retained. o_gnt and o_gnt_enc are unchanged, ptr is not advanced, and the state stays BUSY.
  - Use: multi-beat transfers.
  - If the granted requester's i_req is low, i_lock is ignored and normal arbitration applies.
- Not defined: no i_lock port; behaviour is exactly as above.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with i_req=4'b1111 -> o_gnt=0, o_gnt_vld=0, o_gnt_enc=0. The first grant after release is o_gnt=4'b0001.
- Rotation (W=4): i_req=4'b1111 held, i_ack=1 every cycle -> grants 0,1,2,3,0,1 on consecutive cycles with o_gnt_vld continuously high.
- Wrap with gaps: ptr=3 (after granting 2), i_req=4'b0011 -> grant 0, then 1. Granting 2 again requires i_req[2] to be set.
- Hold without ack: grant to 2, i_ack=0 for 5 cycles while i_req toggles -> o_gnt=4'b0100 and o_gnt_enc=2 stable. ptr advances only on the eventual ack.
- Single requester: i_req=4'b1000 held, i_ack=1 -> o_gnt_vld pattern 1,0,1,0. Grant always 3; ptr steady at 0 after the first ack.
- Lock (RR_ARB_LOCK_EN): grant 1 with i_lock=1 for 3 acks while i_req=4'b0011 -> grant stays 1 for 4 beats. When i_lock=0 on the 4th ack, the next grant is 0 (ptr=2, wrapped).
